// File: rtl/pe_id_config_sequencer_if.sv
// rtl/pe_id_config_sequencer_if.sv - start/generator/ID-table/config-bus signal bundle for the PE ID sequencer
interface pe_id_config_sequencer_if #(
    parameter int XID_W = 5,
    parameter int YID_W = 3
);
    logic             cfg_start;
    logic             cfg_abort;
    logic             idgen_start;
    logic             idgen_x_done;
    logic             idgen_y_done;
    logic [1:0]       id_bus_sel;
    logic [5:0]       id_pe_sel;
    logic [XID_W-1:0] id_xid;
    logic [YID_W-1:0] id_yid;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_bus;
    logic [5:0]       cfg_pe;
    logic [XID_W-1:0] cfg_xid;
    logic [YID_W-1:0] cfg_yid;
    logic [7:0]       cfg_words;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        input  cfg_start, cfg_abort, idgen_x_done, idgen_y_done, id_xid, id_yid, cfg_ready,
        output idgen_start, id_bus_sel, id_pe_sel, cfg_valid, cfg_bus, cfg_pe, cfg_xid,
               cfg_yid, cfg_words, cfg_busy, cfg_done, cfg_err
    );

    modport slave (
        output cfg_start, cfg_abort, idgen_x_done, idgen_y_done, id_xid, id_yid, cfg_ready,
        input  idgen_start, id_bus_sel, id_pe_sel, cfg_valid, cfg_bus, cfg_pe, cfg_xid,
               cfg_yid, cfg_words, cfg_busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/pe_id_config_sequencer.sv
// rtl/pe_id_config_sequencer.sv - kicks the multicast ID generator, then streams its ID tables onto the PE config bus
module pe_id_config_sequencer #(
    parameter int NUM_PE      = 48,
    parameter int XID_W       = 5,
    parameter int YID_W       = 3,
    parameter bit SKIP_UNUSED = 1'b1,
    parameter int GEN_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    pe_id_config_sequencer_if.master cfg
);
    localparam int              WAIT_W    = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GEN_TIMEOUT - 1);
    localparam logic [5:0]      LAST_PE   = 6'(NUM_PE - 1);
    localparam logic [1:0]      LAST_BUS  = 2'd3;

    typedef enum logic [2:0] {IDLE, KICK, WAIT_GEN, SEND, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        bus_cnt;
    logic [5:0]        pe_cnt;
    logic              fetched_all;
    logic              valid_q;
    logic [1:0]        bus_q;
    logic [5:0]        pe_q;
    logic [XID_W-1:0]  xid_q;
    logic [YID_W-1:0]  yid_q;
    logic [7:0]        words_q;
    logic              err_q;

    logic abort_act;
    logic gen_ready;
    logic advance;
    logic skip_word;
    logic kick_go;

    assign abort_act = cfg.cfg_abort && (state != IDLE);
    // The generator still shows the previous pass's done flags during the first wait cycle.
    assign gen_ready = (wait_cnt != '0) && cfg.idgen_x_done && cfg.idgen_y_done;
    assign advance   = (state == SEND) && (!valid_q || cfg.cfg_ready) && !abort_act;
    assign skip_word = SKIP_UNUSED && (&cfg.id_xid) && (&cfg.id_yid);
    assign kick_go   = (state_nxt == KICK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg.cfg_start) state_nxt = KICK;
            end
            KICK: begin
                state_nxt = WAIT_GEN;
            end
            WAIT_GEN: begin
                if (gen_ready) begin
                    state_nxt = SEND;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERR;
                end
            end
            SEND: begin
                if (advance && fetched_all) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                if (cfg.cfg_start) state_nxt = KICK;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort_act) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            bus_cnt     <= '0;
            pe_cnt      <= '0;
            fetched_all <= 1'b0;
            valid_q     <= 1'b0;
            bus_q       <= '0;
            pe_q        <= '0;
            xid_q       <= '0;
            yid_q       <= '0;
            words_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (kick_go) begin
                bus_cnt     <= '0;
                pe_cnt      <= '0;
                fetched_all <= 1'b0;
                words_q     <= '0;
                err_q       <= 1'b0;
            end

            if (state == KICK) begin
                wait_cnt <= '0;
            end else if (state == WAIT_GEN && state_nxt == WAIT_GEN) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == WAIT_GEN && state_nxt == ERR) begin
                err_q <= 1'b1;
            end

            if (cfg.cfg_valid && cfg.cfg_ready && !abort_act && words_q != 8'hff) begin
                words_q <= words_q + 8'd1;
            end

            // Counters point at the next word to fetch and park on the final entry.
            if (advance) begin
                if (fetched_all) begin
                    valid_q <= 1'b0;
                end else begin
                    if (skip_word) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        bus_q   <= bus_cnt;
                        pe_q    <= pe_cnt;
                        xid_q   <= cfg.id_xid;
                        yid_q   <= cfg.id_yid;
                    end
                    if (pe_cnt == LAST_PE) begin
                        if (bus_cnt == LAST_BUS) begin
                            fetched_all <= 1'b1;
                        end else begin
                            pe_cnt  <= '0;
                            bus_cnt <= bus_cnt + 2'd1;
                        end
                    end else begin
                        pe_cnt <= pe_cnt + 6'd1;
                    end
                end
            end

            if (abort_act) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign cfg.idgen_start = (state == KICK);
    assign cfg.id_bus_sel  = bus_cnt;
    assign cfg.id_pe_sel   = pe_cnt;
    assign cfg.cfg_valid   = valid_q;
    assign cfg.cfg_bus     = bus_q;
    assign cfg.cfg_pe      = pe_q;
    assign cfg.cfg_xid     = xid_q;
    assign cfg.cfg_yid     = yid_q;
    assign cfg.cfg_words   = words_q;
    assign cfg.cfg_busy    = (state != IDLE) && (state != ERR);
    assign cfg.cfg_done    = (state == DONE);
    assign cfg.cfg_err     = err_q;
endmodule

// File: tb/tb_pe_id_config_sequencer.sv
// tb/tb_pe_id_config_sequencer.sv - randomized directed bench for pe_id_config_sequencer against a table-walk model
module tb_pe_id_config_sequencer;
    localparam int NUM_PE      = 48;
    localparam int XID_W       = 5;
    localparam int YID_W       = 3;
    localparam bit SKIP        = 1'b1;
    localparam int GEN_TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [XID_W-1:0] tab_x [256];
    logic [YID_W-1:0] tab_y [256];
    logic [15:0]      exp_q [$];
    logic [15:0]      got [$];
    int               done_cnt;
    int               first_v, last_v, vcount;

    pe_id_config_sequencer_if #(.XID_W(XID_W), .YID_W(YID_W)) sif ();

    pe_id_config_sequencer #(
        .NUM_PE(NUM_PE), .XID_W(XID_W), .YID_W(YID_W),
        .SKIP_UNUSED(SKIP), .GEN_TIMEOUT(GEN_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(sif)
    );

    always #5 clk = ~clk;

    always_comb begin
        sif.id_xid = tab_x[{sif.id_bus_sel, sif.id_pe_sel}];
        sif.id_yid = tab_y[{sif.id_bus_sel, sif.id_pe_sel}];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({sif.idgen_start, sif.id_bus_sel, sif.id_pe_sel, sif.cfg_valid, sif.cfg_bus,
                    sif.cfg_pe, sif.cfg_xid, sif.cfg_yid, sif.cfg_words, sif.cfg_busy,
                    sif.cfg_done, sif.cfg_err});
    endfunction

    // mode 0: random, never the unused pair; 1: ipsum unused beyond PE 7; 2: fully random
    task automatic fill(input int mode);
        logic [XID_W-1:0] x;
        logic [YID_W-1:0] y;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            tab_x[i] = '1;
            tab_y[i] = '1;
        end
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < NUM_PE; p++) begin
                x = XID_W'($urandom_range(0, 31));
                y = YID_W'($urandom_range(0, 7));
                if (mode != 2 && x == 5'd31 && y == 3'd7) x = 5'd0;
                if (mode == 1 && b == 2 && p >= 8) begin
                    x = 5'd31;
                    y = 3'd7;
                end
                tab_x[b * 64 + p] = x;
                tab_y[b * 64 + p] = y;
                if (!(SKIP && x == 5'd31 && y == 3'd7))
                    exp_q.push_back({2'(b), 6'(p), x, y});
            end
        end
    endtask

    task automatic run_pass(input int gen_lat, input int rdy_pct, input int kill_idx, input bit kill_rst);
        int          since;
        int          kicks;
        bit          held_v;
        bit          killed;
        bit          ready;
        logic [15:0] held;
        logic [15:0] w;
        got.delete();
        done_cnt = 0;
        first_v  = -1;
        last_v   = -1;
        vcount   = 0;
        kicks    = 0;
        since    = 0;
        held_v   = 1'b0;
        killed   = 1'b0;
        held     = '0;
        @(negedge clk);
        sif.cfg_start = 1'b1;
        @(negedge clk);
        sif.cfg_start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            w = {sif.cfg_bus, sif.cfg_pe, sif.cfg_xid, sif.cfg_yid};
            if (killed) begin
                if (kill_rst) begin
                    chk("rst_all_zero", all_outs(), 64'd0);
                    rst = 1'b0;
                end else begin
                    chk("abort_valid", 64'(sif.cfg_valid), 64'd0);
                    chk("abort_busy", 64'(sif.cfg_busy), 64'd0);
                    chk("abort_done", 64'(sif.cfg_done), 64'd0);
                    chk("abort_words", 64'(sif.cfg_words), 64'(kill_idx));
                    sif.cfg_abort = 1'b0;
                end
                break;
            end
            if (sif.idgen_start) begin
                chk("err_clear_on_kick", 64'(sif.cfg_err), 64'd0);
                kicks++;
                since = 0;
                sif.idgen_x_done = 1'b0;
                sif.idgen_y_done = 1'b0;
            end else if (kicks > 0 && gen_lat >= 0) begin
                since++;
                if (since >= gen_lat) begin
                    sif.idgen_x_done = 1'b1;
                    sif.idgen_y_done = 1'b1;
                end
            end
            if (sif.cfg_done) begin
                done_cnt++;
                chk("done_after_last", 64'(got.size()), 64'(exp_q.size()));
            end
            if (kicks > 0 && !sif.cfg_busy) break;
            if (held_v) begin
                chk("stall_valid", 64'(sif.cfg_valid), 64'd1);
                chk("stall_payload", 64'(w), 64'(held));
            end
            ready = ($urandom_range(0, 99) < rdy_pct);
            sif.cfg_ready = ready;
            if (sif.cfg_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                vcount++;
            end
            if (kill_idx >= 0 && sif.cfg_valid && ready && got.size() == kill_idx) begin
                killed = 1'b1;
                if (kill_rst) rst = 1'b1;
                else sif.cfg_abort = 1'b1;
            end else if (sif.cfg_valid && ready) begin
                got.push_back(w);
            end
            held_v = sif.cfg_valid && !ready;
            held   = w;
            @(negedge clk);
        end
        chk("pass_ended", 64'(sif.cfg_busy), 64'd0);
    endtask

    task automatic verify_seq(input bit full);
        int n;
        if (full) chk("word_count", 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("word%0d", i), 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic check_full_pass();
        verify_seq(1'b1);
        chk("one_done", 64'(done_cnt), 64'd1);
        chk("cfg_words", 64'(sif.cfg_words), 64'((got.size() > 255) ? 255 : got.size()));
    endtask

    initial begin
        int n_hi;
        bit vseen;
        bit eseen;
        sif.cfg_start    = 1'b0;
        sif.cfg_abort    = 1'b0;
        sif.cfg_ready    = 1'b0;
        sif.idgen_x_done = 1'b0;
        sif.idgen_y_done = 1'b0;
        fill(0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", all_outs(), 64'd0);

        // full pass, always ready
        fill(0);
        run_pass(3, 100, -1, 1'b0);
        check_full_pass();
        chk("full_192", 64'(got.size()), 64'd192);
        chk("contiguous", 64'(last_v - first_v + 1), 64'(vcount));
        chk("valid_cycles", 64'(vcount), 64'(got.size()));

        // unused ipsum entries dropped
        fill(1);
        run_pass(3, 100, -1, 1'b0);
        check_full_pass();
        chk("skip_152", 64'(got.size()), 64'd152);
        n_hi = 0;
        foreach (got[i]) if (got[i][15:14] == 2'd2 && got[i][13:8] >= 6'd8) n_hi++;
        chk("no_ipsum_hi", 64'(n_hi), 64'd0);

        // random backpressure
        fill(0);
        run_pass(3, 50, -1, 1'b0);
        check_full_pass();

        // generator never finishes
        sif.idgen_x_done = 1'b0;
        sif.idgen_y_done = 1'b0;
        sif.cfg_ready    = 1'b1;
        @(negedge clk);
        sif.cfg_start = 1'b1;
        @(negedge clk);
        sif.cfg_start = 1'b0;
        chk("kick_pulse", 64'(sif.idgen_start), 64'd1);
        vseen = 1'b0;
        eseen = 1'b0;
        repeat (GEN_TIMEOUT) begin
            @(negedge clk);
            vseen |= sif.cfg_valid;
            eseen |= sif.cfg_err;
        end
        chk("no_err_early", 64'(eseen), 64'd0);
        chk("busy_in_wait", 64'(sif.cfg_busy), 64'd1);
        @(negedge clk);
        chk("err_at_timeout", 64'(sif.cfg_err), 64'd1);
        chk("err_not_busy", 64'(sif.cfg_busy), 64'd0);
        chk("err_no_valid", 64'(vseen | sif.cfg_valid), 64'd0);
        repeat (4) @(negedge clk);
        chk("err_sticky", 64'(sif.cfg_err), 64'd1);
        sif.cfg_start = 1'b1;
        sif.cfg_abort = 1'b1;
        @(negedge clk);
        sif.cfg_start = 1'b0;
        sif.cfg_abort = 1'b0;
        chk("abort_beats_start", 64'({sif.idgen_start, sif.cfg_busy}), 64'd0);
        chk("abort_keeps_err", 64'(sif.cfg_err), 64'd1);
        fill(0);
        run_pass(3, 100, -1, 1'b0);
        check_full_pass();

        // abort while a word is being accepted
        fill(0);
        run_pass(3, 100, 100, 1'b0);
        verify_seq(1'b0);
        chk("abort_got", 64'(got.size()), 64'd100);
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // reset mid-send, then a clean pass
        fill(2);
        run_pass(5, 70, 60, 1'b1);
        verify_seq(1'b0);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        fill(2);
        run_pass(2, 60, -1, 1'b0);
        check_full_pass();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
